gate_vector_checker: RTL and testbench

- Self-checking stimulus/response stage around the team's 2-input gate-primitive block.
- Sequences all four (a,b) input combinations into the gate block and samples its eight outputs (AND, OR, NOR, NAND, XOR, XNOR, NOT a, BUF a).
- Compares each sample against a built-in truth table and reports pass/fail, mismatch count and failing bits to the bench or the top level.

---
 rtl/gate_vector_checker.sv | 162 ++++++++++++++++
 tb/tb_gate_vector_checker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_vector_checker.sv
// Sweeps the four (a,b) vectors through a 2-input gate block and checks its eight outputs.
// Optional build macro GATE_CHK_STOP_ON_FAIL_EN: end a run at the first mismatching vector.
//
// state | meaning
// IDLE  | waiting for start; a/b hold the last driven vector
// WAIT  | settle counter running down after a new vector was driven
// CHECK | compare y_in with the truth table, then advance or finish
// DONE  | publish pass, pulse done, drop busy
module gate_vector_checker #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned PASSES        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] y_in,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] fail_mask,
  output logic [1:0] first_fail_vec
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam logic [7:0] PASS_LAST = 8'(PASSES - 1);

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] settle_q, settle_d;
  logic [7:0] pass_cnt_q, pass_cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [7:0] err_q, err_d;
  logic [7:0] mask_q, mask_d;
  logic [1:0] ffv_q, ffv_d;

  logic [7:0] exp_y;
  logic [7:0] diff;
  logic       mismatch;
  logic       last_vec;
  logic       stop;

  // Bit order: {BUF a, NOT a, XNOR, XOR, NAND, NOR, OR, AND}
  function automatic logic [7:0] expected_y(input logic [1:0] v);
    logic [7:0] y;
    unique case (v)
      2'd0:    y = 8'h6C;
      2'd1:    y = 8'h5A;
      2'd2:    y = 8'h9A;
      default: y = 8'hA3;
    endcase
    return y;
  endfunction

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    settle_d   = settle_q;
    pass_cnt_d = pass_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    mask_d     = mask_q;
    ffv_d      = ffv_q;

    exp_y    = expected_y(vec_q);
    diff     = y_in ^ exp_y;
    // Case inequality so X/Z on y_in is never mistaken for a match.
    mismatch = (y_in !== exp_y);
    last_vec = (vec_q == 2'd3) && (pass_cnt_q == PASS_LAST);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    stop     = mismatch;
`else
    stop     = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d      = 8'd0;
          mask_d     = 8'd0;
          ffv_d      = 2'd0;
          pass_d     = 1'b0;
          vec_d      = 2'd0;
          pass_cnt_d = 8'd0;
          settle_d   = SETTLE_LD;
          busy_d     = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        settle_d = settle_q - 4'd1;
        if (settle_d == 4'd0) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          mask_d = mask_q | diff;
          // err_count never returns to zero mid-run, so zero marks the first miss.
          if (err_q == 8'd0) ffv_d = vec_q;
        end
        if (last_vec || stop) begin
          state_d = S_DONE;
        end else begin
          vec_d    = vec_q + 2'd1;
          settle_d = SETTLE_LD;
          state_d  = S_WAIT;
          if (vec_q == 2'd3) pass_cnt_d = pass_cnt_q + 8'd1;
        end
      end
      default: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_q == 8'd0);
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vec_q      <= 2'd0;
      settle_q   <= 4'd0;
      pass_cnt_q <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 8'd0;
      mask_q     <= 8'd0;
      ffv_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      settle_q   <= settle_d;
      pass_cnt_q <= pass_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      mask_q     <= mask_d;
      ffv_q      <= ffv_d;
    end
  end

  assign a              = vec_q[1];
  assign b              = vec_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_mask      = mask_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: two instances (settle/passes 1/1 and 4/3) driven by a faultable gate model.
module tb_gate_vector_checker;

  localparam int S0 = 1;
  localparam int P0 = 1;
  localparam int S1 = 4;
  localparam int P1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_r;
  logic       sel;
  logic [7:0] and_m, or_m, xor_m;
  int         checks;
  int         errors;

  logic       start0, start1;
  logic [7:0] y0, y1;
  logic       a0, b0, busy0, done0, pass0;
  logic       a1, b1, busy1, done1, pass1;
  logic [7:0] err0, mask0, err1, mask1;
  logic [1:0] ffv0, ffv1;

  logic       o_a, o_b, o_busy, o_done, o_pass;
  logic [7:0] o_err, o_mask;
  logic [1:0] o_ffv;

  // Behavioural 2-input gate block: {BUF a, NOT a, XNOR, XOR, NAND, NOR, OR, AND}
  function automatic logic [7:0] gate(input logic ia, input logic ib);
    return {ia, ~ia, ~(ia ^ ib), ia ^ ib, ~(ia & ib), ~(ia | ib), ia | ib, ia & ib};
  endfunction

  assign y0     = ((gate(a0, b0) & and_m) | or_m) ^ xor_m;
  assign y1     = ((gate(a1, b1) & and_m) | or_m) ^ xor_m;
  assign start0 = start_r & ~sel;
  assign start1 = start_r & sel;

  assign o_a    = sel ? a1    : a0;
  assign o_b    = sel ? b1    : b0;
  assign o_busy = sel ? busy1 : busy0;
  assign o_done = sel ? done1 : done0;
  assign o_pass = sel ? pass1 : pass0;
  assign o_err  = sel ? err1  : err0;
  assign o_mask = sel ? mask1 : mask0;
  assign o_ffv  = sel ? ffv1  : ffv0;

  gate_vector_checker #(.SETTLE_CYCLES(S0), .PASSES(P0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .y_in(y0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_mask(mask0), .first_fail_vec(ffv0)
  );

  gate_vector_checker #(.SETTLE_CYCLES(S1), .PASSES(P1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .y_in(y1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_mask(mask1), .first_fail_vec(ffv1)
  );

  // Reference: walk every vector of every pass, compare the faulted gate output against the true gate.
  task automatic compute_model(input int passes, output int nv, output logic [7:0] e_err,
                               output logic [7:0] e_mask, output logic [1:0] e_ffv, output bit e_pass);
    logic [7:0] tr, obs;
    int v;
    nv = 4 * passes; e_err = 8'd0; e_mask = 8'd0; e_ffv = 2'd0;
    for (int g = 0; g < 4 * passes; g++) begin
      v   = g % 4;
      tr  = gate(1'(v / 2), 1'(v % 2));
      obs = ((tr & and_m) | or_m) ^ xor_m;
      if (obs != tr) begin
        if (e_err == 8'd0) e_ffv = 2'(v);
        if (e_err != 8'hFF) e_err = e_err + 8'd1;
        e_mask = e_mask | (obs ^ tr);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        nv = g + 1;
        break;
`endif
      end
    end
    e_pass = (e_err == 8'd0);
  endtask

  // Caller raises start_r (at #1 after an edge); this waits for the start edge and follows the run.
  task automatic run_check(input string tag, input bit keep_start, input bit jitter);
    int s, p, nv, L, seg, v;
    logic [7:0] e_err, e_mask;
    logic [1:0] e_ffv;
    bit e_pass;
    logic [3:0] exp_sig, got;
    s = sel ? S1 : S0;
    p = sel ? P1 : P0;
    compute_model(p, nv, e_err, e_mask, e_ffv, e_pass);
    L = nv * (s + 1) + 1;
    @(posedge clk); #1;
    for (int t = 0; t <= L; t++) begin
      seg = t / (s + 1);
      if (seg > nv - 1) seg = nv - 1;
      v = seg % 4;
      exp_sig = {v[1], v[0], (t < L), (t == L)};
      got = {o_a, o_b, o_busy, o_done};
      checks++;
      if (got !== exp_sig)
        begin errors++; $display("FAIL %s seq t=%0d {a,b,busy,done} got %b exp %b", tag, t, got, exp_sig); end
      if (t < L) begin
        if (keep_start) start_r = 1'b1;
        else if (jitter) start_r = 1'($urandom_range(0, 1));
        else start_r = 1'b0;
        @(posedge clk); #1;
      end
    end
    checks++;
    if (o_err !== e_err) begin errors++; $display("FAIL %s err_count got %0d exp %0d", tag, o_err, e_err); end
    checks++;
    if (o_mask !== e_mask) begin errors++; $display("FAIL %s fail_mask got %h exp %h", tag, o_mask, e_mask); end
    checks++;
    if (o_ffv !== e_ffv) begin errors++; $display("FAIL %s first_fail_vec got %0d exp %0d", tag, o_ffv, e_ffv); end
    checks++;
    if (o_pass !== e_pass) begin errors++; $display("FAIL %s pass got %b exp %b", tag, o_pass, e_pass); end
    if (!keep_start) begin
      start_r = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({o_busy, o_done} !== 2'b00)
        begin errors++; $display("FAIL %s idle_after {busy,done} got %b exp 00", tag, {o_busy, o_done}); end
    end
  endtask

  task automatic clean_gate();
    and_m = 8'hFF; or_m = 8'h00; xor_m = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_r = 1'b0; sel = 1'b0; clean_gate();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a0, b0, busy0, done0, pass0, err0, mask0, ffv0} !== 23'd0)
      begin errors++; $display("FAIL reset dut0 got %h exp 0", {a0, b0, busy0, done0, pass0, err0, mask0, ffv0}); end
    checks++;
    if ({a1, b1, busy1, done1, pass1, err1, mask1, ffv1} !== 23'd0)
      begin errors++; $display("FAIL reset dut1 got %h exp 0", {a1, b1, busy1, done1, pass1, err1, mask1, ffv1}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    sel = 1'b0; clean_gate();
    start_r = 1'b1; run_check("clean_s1p1", 1'b0, 1'b0);
    and_m = 8'hEF;
    start_r = 1'b1; run_check("xor_stuck0", 1'b0, 1'b0);
    sel = 1'b1; and_m = 8'h00;
    start_r = 1'b1; run_check("tied0_p3", 1'b0, 1'b0);
    clean_gate();
    start_r = 1'b1; run_check("clean_s4p3", 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    sel = 1'b0; clean_gate(); xor_m = 8'h01;
    start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if ({o_a, o_b, o_busy, o_err} !== {1'b1, 1'b0, 1'b1, 8'd2})
      begin errors++; $display("FAIL midrun_pre {a,b,busy,err} got %h exp %h", {o_a, o_b, o_busy, o_err}, {1'b1, 1'b0, 1'b1, 8'd2}); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({o_a, o_b, o_busy, o_done, o_pass, o_err, o_mask, o_ffv} !== 23'd0)
      begin errors++; $display("FAIL midrun_rst outputs got %h exp 0", {o_a, o_b, o_busy, o_done, o_pass, o_err, o_mask, o_ffv}); end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({o_busy, o_done} !== 2'b00)
        begin errors++; $display("FAIL midrun_quiet cyc=%0d {busy,done} got %b exp 00", i, {o_busy, o_done}); end
    end
    clean_gate();
    start_r = 1'b1; run_check("after_rst", 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s); clean_gate();
      start_r = 1'b1;
      run_check("b2b_run0", 1'b1, 1'b0);
      or_m = 8'h40;
      run_check("b2b_run1", 1'b1, 1'b0);
      clean_gate();
      run_check("b2b_run2", 1'b0, 1'b0);
    end
  endtask

  task automatic test_busy_pulses();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s); clean_gate(); xor_m = 8'h88;
      start_r = 1'b1; run_check("busy_pulses", 1'b0, 1'b1);
    end
  endtask

  task automatic test_random();
    int mode;
    for (int i = 0; i < 16; i++) begin
      sel = 1'($urandom_range(0, 1));
      clean_gate();
      mode = $urandom_range(0, 3);
      case (mode)
        1: and_m = ~(8'd1 << $urandom_range(0, 7));
        2: or_m  = 8'd1 << $urandom_range(0, 7);
        3: xor_m = 8'($urandom);
        default: ;
      endcase
      start_r = 1'b1;
      run_check("random", 1'b0, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start_r = 1'b0; sel = 1'b0;
    and_m = 8'hFF; or_m = 8'h00; xor_m = 8'h00;
    test_reset();
    test_directed();
    test_reset_mid_run();
    test_back_to_back();
    test_busy_pulses();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
